// File: rtl/keypad_if.sv
// Keypad matrix pins plus the decoded key stream of keypad_scanner.
// master = scanner side, slave = consumer / keypad model side.
interface keypad_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (input col, output row, key, key_valid, key_held);
  modport slave  (output col, input row, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, col sync, whole-scan debounce, key code output.
// Define KEYPAD_REPEAT_EN to get auto-repeat key_valid pulses while a key is held.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 25
) (
  input  logic     clk,
  input  logic     reset,
  keypad_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]    col_m, col_s;
  logic [DW-1:0] div;
  logic [1:0]    ridx;
  logic [1:0]    hits, hits_n;
  logic [3:0]    first, first_n;
  logic          tick, scan_end;

  assign tick     = (div == DW'(SCAN_DIV - 1));
  assign scan_end = tick && (ridx == 2'd3);
  assign kp.row   = ~(4'b0001 << ridx);

  // Fold the current row's sample into the running scan totals.
  logic [2:0] row_hits, hits_sum;
  logic [1:0] row_first;
  logic       found;
  always_comb begin
    row_hits  = '0;
    row_first = '0;
    found     = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s[c]) begin
        row_hits = row_hits + 3'd1;
        if (!found) begin
          row_first = 2'(c);
          found     = 1'b1;
        end
      end
    end
    hits_sum = {1'b0, hits} + row_hits;
    hits_n   = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    first_n  = (hits == 2'd0 && found) ? {ridx, row_first} : first;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      div   <= '0;
      ridx  <= '0;
      hits  <= '0;
      first <= '0;
    end else begin
      col_m <= kp.col;
      col_s <= col_m;
      if (tick) begin
        div   <= '0;
        ridx  <= ridx + 2'd1;
        hits  <= scan_end ? 2'd0 : hits_n;
        first <= scan_end ? 4'd0 : first_n;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  logic res_none, res_single;
  assign res_none   = (hits_n == 2'd0);
  assign res_single = (hits_n == 2'd1);

  state_t        state, state_n;
  logic [3:0]    cand, cand_n, key_r, key_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          kv_r, kv_n, rep_fire;

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    key_n   = key_r;
    kv_n    = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: if (res_single) begin
          cand_n = first_n;
          cnt_n  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            state_n = PRESSED;
            key_n   = first_n;
            kv_n    = 1'b1;
          end else begin
            state_n = DEBOUNCE;
          end
        end
        DEBOUNCE: if (res_single && first_n == cand) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
            state_n = PRESSED;
            key_n   = cand;
            kv_n    = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
        // Rollover/ghosting while held is deliberately ignored; only silence releases.
        PRESSED: if (res_none) begin
          cnt_n   = CW'(1);
          state_n = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
        end
        RELEASE: if (res_none) begin
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(DEBOUNCE_SCANS)) state_n = IDLE;
        end else begin
          state_n = PRESSED;
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  logic [RW-1:0] rep, rep_n, rep_inc;
  assign rep_inc = rep + 1'b1;

  always_comb begin
    rep_n    = rep;
    rep_fire = 1'b0;
    if (state_n == PRESSED && state != PRESSED) begin
      rep_n = '0;
    end else if (scan_end && state == PRESSED) begin
      if (res_single && first_n == key_r) begin
        if (rep_inc == RW'(REPEAT_SCANS)) begin
          rep_fire = 1'b1;
          rep_n    = '0;
        end else begin
          rep_n = rep_inc;
        end
      end else if (!res_single) begin
        rep_n = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep <= '0;
    else       rep <= rep_n;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      key_r <= '0;
      kv_r  <= 1'b0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      key_r <= key_n;
      kv_r  <= kv_n | rep_fire;
    end
  end

  assign kp.key       = key_r;
  assign kp.key_valid = kv_r;
  assign kp.key_held  = (state == PRESSED) || (state == RELEASE);
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the stopwatch's multiplexed 7-segment display path.
- The display side drives a scanned set of active-low strobes. This block drives active-low row strobes into a 4x4 matrix keypad and reads back the active-low column lines.
- Column reads are synchronized and debounced; each debounced press emits one 4-bit key code with a single-cycle valid pulse.
- Feeds control logic such as play/pause, reset and preset entry for the stopwatch counters.

Parameters:
- SCAN_DIV, 50000: clk cycles each row strobe is held. Must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results needed to accept a press or a release. Must be >= 1.
- REPEAT_SCANS, 25: full scans between auto-repeat pulses. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- col  input  4  keypad columns, active-low, externally pulled up; asynchronous to clk.
- row  output  4  row strobes, active-low one-hot.
- key  output  4  code of the last accepted key, computed as row*4 + column.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key is debounced-pressed.

Behaviour:
- Reset values, applied asynchronously: row=4'b1110, key=0, key_valid=0, key_held=0, FSM=IDLE, divider=0, row index=0, scan accumulators cleared, col synchronizer=4'b1111.
- Synchronizer: col passes through a 2-flop synchronizer (col_s) before any use.
- Divider: counts 0..SCAN_DIV-1. tick = (divider == SCAN_DIV-1).
  - On tick: sample col_s for the current row, then advance the row index 0→1→2→3→0.
  - row sequence: 1110, 1101, 1011, 0111, repeating.
- Per-row sample: a column reads pressed when its col_s bit = 0. Columns 0..3 map to col[0]..col[3].
- Scan accumulators, updated during each scan:
  - hits: pressed-key count, saturating at 2.
  - first: code of the first pressed key, scanning rows 0..3 then columns 0..3.
- scan_end: the tick on which row 3 is sampled. Its result is classified as:
  - NONE: hits = 0.
  - SINGLE(first): hits = 1.
  - MULTI: hits >= 2.
  - Accumulators clear for the next scan after classification.
- FSM, evaluated only on scan_end; cnt is the debounce counter:
  - IDLE: SINGLE(c) → DEBOUNCE with cand=c, cnt=1. Otherwise stay.
  - DEBOUNCE: SINGLE(cand) → cnt+1.
    - When cnt reaches DEBOUNCE_SCANS → PRESSED, key<=cand, key_valid=1 for the next clk cycle only.
    - Any other result → IDLE.
    - With DEBOUNCE_SCANS=1, the accept happens directly from IDLE: IDLE→PRESSED on the first SINGLE.
  - PRESSED: key_held=1. NONE → RELEASE, cnt=1. SINGLE of any code or MULTI → stay. Key rollover and ghosting are ignored.
  - RELEASE: NONE → cnt+1; at DEBOUNCE_SCANS → IDLE, key_held=0. Anything else → PRESSED, with no new key_valid.
- Output timing: key and key_valid update together, registered, 1 cycle after the accepting scan_end. key_held rises in the same cycle as key_valid and falls 1 cycle after the final release scan_end.
- key holds its value until the next accept.
- A press with MULTI in any scan before acceptance produces no output.
- Reset mid-operation returns to IDLE. A partially debounced press is discarded and no pulse is emitted.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter increments on each scan_end whose result is SINGLE(key).
  - When the counter reaches REPEAT_SCANS, key_valid pulses again with the unchanged key, and the counter restarts at 0.
  - The counter clears on entering PRESSED and on any NONE or MULTI result.
- Undefined: no repeat logic. Exactly one key_valid per accepted press.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3; one scan = 16 cycles; the bench model drives col=1101 when row==1011 for key 9):
- Assert reset mid-scan → row=1110, key=0, key_valid=0, key_held=0 immediately. After release, row steps through 1110, 1101, 1011, 0111, each held 4 cycles.
- Hold key 9 for 4 scans → exactly one key_valid pulse with key=9, 1 cycle after the 2nd scan_end; key_held=1. Release → key_held=0 after 2 empty scans; no further pulse.
- Press key 9 for 1 scan only (bounce), then release → no key_valid; key_held stays 0; key stays 0.
- Press keys 0 and 7 together → no pulse. Then key 5 alone until accepted (key=5), then add key 14 → key_held stays 1, no new pulse, key stays 5.
- Assert reset after the 1st consistent scan of key 3 → no key_valid; after release, key 3 needs 2 fresh scans to be accepted.
- KEYPAD_REPEAT_EN defined, key 12 held for 10 scans → pulses after scans 2, 5 and 8 (3 total), all with key=12. Undefined → a single pulse.
